reg_file_ser_master: RTL

// Upstream bridge for the serial register-file slave. Accepts parallel read/write

---
 rtl/reg_file_ser_master_if.sv | 34 +++
 rtl/reg_file_ser_master.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_ser_master_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_ser_master_if
// Brief    : Parallel request/response bus between a control-path master
//            and the serial register-file bridge.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_file_ser_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  busy;

  // Side that issues requests and consumes responses (CPU / test port).
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  // Side that accepts requests and produces responses (the bridge).
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_ser_master.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_ser_master
// Brief    : Serialises parallel register read/write requests into the
//            1-bit strobe/DIN/DOUT protocol of the serial register file and
//            deserialises read data into a parallel response.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_ser_master #(
  parameter int ADDR_WIDTH = 8,   // slave frame is fixed: only 8 is meaningful
  parameter int DATA_WIDTH = 8    // slave frame is fixed: only 8 is meaningful
) (
  input  wire logic               CLK,
  input  wire logic               RSTN,
  reg_file_ser_master_if.slave    bus,
  output logic                    RD_EN,
  output logic                    WR_EN,
  output logic                    DIN,
  input  wire logic               DOUT
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    STRB = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    RESP = 3'd4,
    GAP  = 3'd5
  } state_t;

  state_t                state_q,     state_d;
  logic [3:0]            cnt_q,       cnt_d;
  logic                  wr_q,        wr_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic [DATA_WIDTH-1:0] shift_q,     shift_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  busy_q,      busy_d;
  logic                  rd_en_q,     rd_en_d;
  logic                  wr_en_q,     wr_en_d;
  logic                  din_q,       din_d;

  logic [2:0]            addr_idx;
  logic [2:0]            data_idx;

  // ADDR sends bits 6..0 (bit 7 already went out in STRB); DATA sends 7..0.
  assign addr_idx = 3'd6 - cnt_q[2:0];
  assign data_idx = 3'd7 - cnt_q[2:0];

  // Next-state and registered-output computation for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    din_d       = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        // Accept only when ready was already visible to the master.
        if (bus.req_valid && req_ready_q) begin
          wr_d        = bus.req_wr;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          req_ready_d = 1'b0;
          wr_en_d     = bus.req_wr;
          rd_en_d     = ~bus.req_wr;
          shift_d     = '0;
          cnt_d       = 4'd0;
          state_d     = STRB;
        end
      end
      STRB: begin
        // Strobe drops; address MSB is launched alongside.
        din_d   = addr_q[7];
        cnt_d   = 4'd0;
        state_d = ADDR;
      end
      ADDR: begin
        din_d = addr_q[addr_idx];
        if (cnt_q == 4'd6) begin
          cnt_d   = 4'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DATA: begin
        if (cnt_q == 4'd8) begin
          // Last read bit arrives on this edge, so fold it straight in.
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wr_q ? '0 : {shift_q[6:0], DOUT};
          cnt_d       = 4'd0;
          state_d     = RESP;
        end else begin
          din_d = wr_q ? wdata_q[data_idx] : 1'b0;
          // Slave read data is valid from the second DATA edge onward.
          if (cnt_q != 4'd0) begin
            shift_d = {shift_q[6:0], DOUT};
          end
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = GAP;
        end
      end
      GAP: begin
        // One idle cycle lets the slave finish its write before a new strobe.
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      shift_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      din_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      din_q       <= din_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busy      = busy_q;
  assign RD_EN         = rd_en_q;
  assign WR_EN         = wr_en_q;
  assign DIN           = din_q;

endmodule
`default_nettype wire
